// File: rtl/dcm_clkgen_prog.sv
// dcm_clkgen_prog: serial programming driver for a Spartan-6 DCM_CLKGEN.
// Takes one M/D request, shifts out LoadD, LoadM and Go over PROGEN/PROGDATA,
// then waits for a fresh PROGDONE and reports done or err.
module dcm_clkgen_prog #(
  parameter int GAP_CYCLES   = 2,
  parameter int DONE_TIMEOUT = 65535
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic [7:0] d_minus1,
  input  logic [7:0] m_minus1,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       prog_en,
  output logic       prog_data,
  input  logic       prog_done
);

  // Phase counter must hold both the 10-bit load length and the gap length.
  localparam int CW = (GAP_CYCLES > 10) ? $clog2(GAP_CYCLES) : 4;
  localparam int TW = $clog2(DONE_TIMEOUT + 1);

  localparam logic [CW-1:0] LOAD_LAST = CW'(9);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] T_LAST    = TW'(DONE_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_D    = 3'd1,
    GAP1      = 3'd2,
    LOAD_M    = 3'd3,
    GAP2      = 3'd4,
    GO        = 3'd5,
    WAIT_DONE = 3'd6
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   cnt;
  logic [TW-1:0]   tcnt;
  logic [9:0]      sr;
  logic [7:0]      m_q;
  logic            seen_low;

  logic            accept;
  logic            bad_req;
  logic            complete;
  logic            timeout;
  logic            busy_d;
  logic            done_d;
  logic            err_d;
  logic            prog_en_d;

  // The serial bit is always the low end of the shift register, which is
  // all-zero outside the two load phases (zero fill on every shift).
  assign prog_data = sr[0];

  // Next-state selection; also flags the events that drive the outputs.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    bad_req   = 1'b0;
    complete  = 1'b0;
    timeout   = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (m_minus1 == 8'd0) begin
            bad_req = 1'b1;
          end else begin
            accept    = 1'b1;
            state_nxt = LOAD_D;
          end
        end
      end
      LOAD_D:    if (cnt == LOAD_LAST) state_nxt = GAP1;
      GAP1:      if (cnt == GAP_LAST)  state_nxt = LOAD_M;
      LOAD_M:    if (cnt == LOAD_LAST) state_nxt = GAP2;
      GAP2:      if (cnt == GAP_LAST)  state_nxt = GO;
      GO:        state_nxt = WAIT_DONE;
      WAIT_DONE: begin
        // A PROGDONE high only counts once it has been seen low after the
        // load began; completion on the last allowed cycle beats timeout.
        if (prog_done && seen_low) begin
          complete  = 1'b1;
          state_nxt = IDLE;
        end else if (tcnt == T_LAST) begin
          timeout   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default:   state_nxt = IDLE;
    endcase
  end

  // Output decode from the state being entered, so the registered outputs
  // line up with that state's first cycle.
  always_comb begin
    prog_en_d = (state_nxt == LOAD_D) || (state_nxt == LOAD_M) || (state_nxt == GO);
    busy_d    = (state_nxt != IDLE);
    done_d    = complete;
    err_d     = bad_req | timeout;
  end

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      tcnt     <= '0;
      sr       <= '0;
      seen_low <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      prog_en  <= 1'b0;
    end else begin
      state   <= state_nxt;
      busy    <= busy_d;
      done    <= done_d;
      err     <= err_d;
      prog_en <= prog_en_d;

      cnt <= (state_nxt != state) ? '0 : cnt + 1'b1;

      if (state == WAIT_DONE && state_nxt == WAIT_DONE)
        tcnt <= tcnt + 1'b1;
      else
        tcnt <= '0;

      if (accept)
        sr <= {d_minus1, 2'b01};
      else if (state == GAP1 && state_nxt == LOAD_M)
        sr <= {m_q, 2'b11};
      else
        sr <= {1'b0, sr[9:1]};

      if (accept)
        seen_low <= 1'b0;
      else if (!prog_done)
        seen_low <= 1'b1;
    end
  end

  // M is held until the LoadM word is built; D goes straight into the shifter.
  always_ff @(posedge clk) begin
    if (accept) m_q <= m_minus1;
  end

endmodule

// File: tb/tb_dcm_clkgen_prog.sv
// Testbench for dcm_clkgen_prog: directed scenarios with literal expectations
// plus a randomized run, all checked every cycle against a timeline model.
module tb_dcm_clkgen_prog;

  localparam int G  = 2;
  localparam int DT = 8;
  localparam int W0 = 22 + 2 * G;   // first WAIT_DONE cycle after acceptance

  logic       clk = 1'b0;
  logic       rst;
  logic       req;
  logic [7:0] d_minus1;
  logic [7:0] m_minus1;
  logic       busy, done, err, prog_en, prog_data;
  logic       prog_done;

  dcm_clkgen_prog #(.GAP_CYCLES(G), .DONE_TIMEOUT(DT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .d_minus1  (d_minus1),
    .m_minus1  (m_minus1),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .prog_en   (prog_en),
    .prog_data (prog_data),
    .prog_done (prog_done)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int ncyc   = 0;
  logic chk_on = 1'b0;

  task automatic check(input string name, input int got, input int want);
    n_chk++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, got, want);
    end
  endtask

  // Expected serial output for the k-th cycle after acceptance.
  function automatic void exp_stream(input int k, input logic [9:0] dw,
                                     input logic [9:0] mw,
                                     output logic en, output logic dat);
    en  = 1'b0;
    dat = 1'b0;
    if (k >= 1 && k <= 10) begin
      en  = 1'b1;
      dat = dw[k-1];
    end else if (k >= 11 + G && k <= 20 + G) begin
      en  = 1'b1;
      dat = mw[k-11-G];
    end else if (k == 21 + 2 * G) begin
      en = 1'b1;
    end
  endfunction

  // Reference model: timeline keyed on cycles since acceptance.
  logic e_busy = 0, e_done = 0, e_err = 0, e_en = 0, e_data = 0;
  logic m_busy = 0, m_seen = 0;
  int   m_k = 0;
  logic [9:0] m_dw = '0, m_mw = '0;

  initial begin
    logic fin_ok, fin_to;
    forever begin
      @(posedge clk);
      ncyc++;
      if (rst) begin
        m_busy = 0; e_busy = 0; e_done = 0; e_err = 0; e_en = 0; e_data = 0;
      end else if (!m_busy) begin
        e_busy = 0; e_done = 0; e_err = 0; e_en = 0; e_data = 0;
        if (req) begin
          if (m_minus1 == 8'd0) begin
            e_err = 1;
          end else begin
            m_busy = 1; m_k = 1; m_seen = 0;
            m_dw = {d_minus1, 2'b01};
            m_mw = {m_minus1, 2'b11};
            e_busy = 1;
            exp_stream(m_k, m_dw, m_mw, e_en, e_data);
          end
        end
      end else begin
        fin_ok = 0;
        fin_to = 0;
        if (m_k >= W0) begin
          if (prog_done && m_seen) fin_ok = 1;
          else if (m_k - (W0 - 1) == DT) fin_to = 1;
        end
        if (!prog_done) m_seen = 1;
        if (fin_ok || fin_to) begin
          m_busy = 0; e_busy = 0; e_en = 0; e_data = 0;
          e_done = fin_ok; e_err = fin_to;
        end else begin
          m_k++;
          e_busy = 1; e_done = 0; e_err = 0;
          exp_stream(m_k, m_dw, m_mw, e_en, e_data);
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_on) begin
        check("busy", int'(busy), int'(e_busy));
        check("done", int'(done), int'(e_done));
        check("err", int'(err), int'(e_err));
        check("prog_en", int'(prog_en), int'(e_en));
        check("prog_data", int'(prog_data), int'(e_data));
      end
    end
  end

  // Directed-run recording and per-cycle actions.
  logic r_en[0:127], r_data[0:127], r_busy[0:127], r_done[0:127], r_err[0:127];
  int   pd_c[3];
  logic pd_v[3];
  int   rst_on, req_off;

  task automatic clear_actions();
    for (int i = 0; i < 3; i++) begin pd_c[i] = -1; pd_v[i] = 1'b0; end
    rst_on  = -1;
    req_off = 1;
  endtask

  task automatic run(input logic [7:0] dv, input logic [7:0] mv, input int n);
    @(negedge clk);
    req = 1'b1; d_minus1 = dv; m_minus1 = mv;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      r_en[c] = prog_en; r_data[c] = prog_data; r_busy[c] = busy;
      r_done[c] = done;  r_err[c] = err;
      if (c == req_off) req = 1'b0;
      for (int i = 0; i < 3; i++) if (c == pd_c[i]) prog_done = pd_v[i];
      if (c == rst_on) rst = 1'b1;
      if (c == rst_on + 1) rst = 1'b0;
    end
    req = 1'b0;
  endtask

  function automatic int first_done(input int from, input int n);
    for (int c = from; c <= n; c++) if (r_done[c]) return c;
    return 0;
  endfunction

  function automatic int first_err(input int n);
    for (int c = 1; c <= n; c++) if (r_err[c]) return c;
    return 0;
  endfunction

  function automatic int en_rises(input int n);
    int r = 0;
    for (int c = 1; c <= n; c++) if (r_en[c] && (c == 1 || !r_en[c-1])) r++;
    return r;
  endfunction

  function automatic int any_busy(input int n);
    for (int c = 1; c <= n; c++) if (r_busy[c]) return 1;
    return 0;
  endfunction

  initial begin
    logic [9:0] got_d, got_m;
    rst = 1'b1; req = 1'b0; d_minus1 = '0; m_minus1 = '0; prog_done = 1'b0;
    clear_actions();
    repeat (3) @(negedge clk);
    chk_on = 1'b1;
    check("reset_busy", int'(busy), 0);
    check("reset_prog_en", int'(prog_en), 0);
    rst = 1'b0;

    // Valid request D=50, M=3; PROGDONE rises in cycle 30.
    clear_actions();
    pd_c[0] = 30; pd_v[0] = 1'b1;
    run(8'h31, 8'h02, 40);
    for (int i = 0; i < 10; i++) begin
      got_d[i] = r_data[i+1];
      got_m[i] = r_data[i+13];
    end
    check("loadd_stream", int'(got_d), int'(10'b0011000101));
    check("loadm_stream", int'(got_m), int'(10'b0000001011));
    check("go_en_c25", int'(r_en[25]), 1);
    check("go_data_c25", int'(r_data[25]), 0);
    check("gap_en_c23", int'(r_en[23]), 0);
    check("busy_c1", int'(r_busy[1]), 1);
    check("done_cycle", first_done(1, 40), 31);
    prog_done = 1'b0;

    // Illegal M.
    clear_actions();
    run(8'h10, 8'h00, 6);
    check("illegal_err_cycle", first_err(6), 1);
    check("illegal_en_bursts", en_rises(6), 0);
    check("illegal_busy", any_busy(6), 0);

    // Timeout: PROGDONE stays low.
    clear_actions();
    run(8'h05, 8'h07, 40);
    check("timeout_err_cycle", first_err(40), 26 + DT);
    check("timeout_no_done", first_done(1, 40), 0);

    // Stale PROGDONE high must be ignored until it has dropped.
    clear_actions();
    prog_done = 1'b1;
    pd_c[0] = 28; pd_v[0] = 1'b0;
    pd_c[1] = 31; pd_v[1] = 1'b1;
    run(8'hA5, 8'h3C, 40);
    check("stale_done_cycle", first_done(1, 40), 32);
    prog_done = 1'b0;

    // Reset in the middle of LoadM, then a normal request.
    clear_actions();
    rst_on = 15;
    run(8'h31, 8'h02, 20);
    check("rst_en_c16", int'(r_en[16]), 0);
    check("rst_busy_c16", int'(r_busy[16]), 0);
    clear_actions();
    pd_c[0] = 30; pd_v[0] = 1'b1;
    run(8'hFF, 8'hFF, 40);
    check("post_rst_done", first_done(1, 40), 31);
    prog_done = 1'b0;

    // req held high across two completions.
    clear_actions();
    req_off = 61;
    pd_c[0] = 30; pd_v[0] = 1'b1;
    pd_c[1] = 31; pd_v[1] = 1'b0;
    pd_c[2] = 60; pd_v[2] = 1'b1;
    run(8'h00, 8'h01, 75);
    check("hold_done1", first_done(1, 75), 31);
    check("hold_busy_c31", int'(r_busy[31]), 0);
    check("hold_busy_c32", int'(r_busy[32]), 1);
    check("hold_done2", first_done(32, 75), 61);
    check("hold_en_bursts", en_rises(75), 6);
    prog_done = 1'b0;

    // Randomized traffic.
    clear_actions();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      req      = ($urandom_range(0, 7) == 0);
      d_minus1 = 8'($urandom);
      m_minus1 = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      if ($urandom_range(0, 3) == 0) prog_done = ~prog_done;
      rst      = ($urandom_range(0, 299) == 0);
    end
    @(negedge clk);
    rst = 1'b0; req = 1'b0;
    repeat (2) @(negedge clk);
    chk_on = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit after %0d cycles", ncyc);
    $fatal(1);
  end

endmodule

// File: doc/dcm_clkgen_prog.md
# dcm_clkgen_prog

Drives the serial programming port (PROGEN/PROGDATA) of a Spartan-6 DCM_CLKGEN at run time, so the synthesized output frequency (M/D) can change without reconfiguring the FPGA. It sits beside the DCM_CLKGEN instance in the parent design. Its clk also feeds the DCM's PROGCLK. It accepts a single M/D request, then serializes LoadD, LoadM and Go commands, waits for PROGDONE, and reports completion or timeout.

## Interface
- GAP_CYCLES, 2: PROGEN-low cycles between LoadD, LoadM and Go commands (≥1).
- DONE_TIMEOUT, 65535: max cycles to wait for PROGDONE after Go before flagging error (≥1).

- clk  in  1  clock; also drives DCM PROGCLK in parent (≤ 400 MHz). Reset is synchronous and active-high.
- rst  in  1  synchronous active-high reset.
- req  in  1  request pulse/level; sampled only while busy=0.
- d_minus1  in  8  D−1 (D = 1..256); captured on accepted req.
- m_minus1  in  8  M−1 (M = 2..256); captured on accepted req; 0 is illegal.
- busy  out  1  high from the cycle after acceptance until done/err cycle.
- done  out  1  one-cycle pulse: programming complete.
- err  out  1  one-cycle pulse: illegal M or PROGDONE timeout.
- prog_en  out  1  to DCM PROGEN, registered.
- prog_data  out  1  to DCM PROGDATA, registered.
- prog_done  in  1  from DCM PROGDONE.

## Operation
- Reset values: busy=0, done=0, err=0, prog_en=0, prog_data=0, FSM=IDLE, counters 0.
- FSM states: IDLE, LOAD_D, GAP1, LOAD_M, GAP2, GO, WAIT_DONE.
- IDLE: on req=1, capture d_minus1 and m_minus1. If m_minus1==0, pulse err next cycle, stay IDLE, never assert prog_en. Otherwise go to LOAD_D.
- LOAD_D: 10 cycles, prog_en=1. prog_data = 1, 0, then d_minus1[0..7], LSB first.
- GAP1 / GAP2: GAP_CYCLES cycles, prog_en=0, prog_data=0.
- LOAD_M: 10 cycles, prog_en=1. prog_data = 1, 1, then m_minus1[0..7], LSB first.
- GO: 1 cycle, prog_en=1, prog_data=0.
- WAIT_DONE: prog_en=0. Finishes when prog_done=1 and a seen_low flag is set.
  - seen_low is cleared on entry to LOAD_D and set whenever prog_done=0 is sampled. This ignores stale PROGDONE from before the load.
- Completion: done pulses and FSM returns to IDLE.
- Timeout: a counter runs only in WAIT_DONE. When it reaches DONE_TIMEOUT without completion, err pulses and FSM returns to IDLE.
- req while busy=1 is ignored; it is not queued.
- Shift register: 10-bit, loaded with the {value, cmd} word on state entry, shifted right each cycle; prog_data = bit 0.
- Timeout counter width: clog2(DONE_TIMEOUT+1).

## Timing
- Edge 0 samples req=1 with valid M. Then, with GAP_CYCLES=2:
  - cycle 1: busy=1, prog_en=1, prog_data=1 (LoadD bit 0).
  - cycles 1–10: LoadD.
  - cycles 11–12: gap.
  - cycles 13–22: LoadM.
  - cycles 23–24: gap.
  - cycle 25: Go.
  - cycle 26 onward: WAIT_DONE.
- General latency to Go: 21 + 2·GAP_CYCLES cycles after acceptance.
- If prog_done is sampled high (with seen_low) at edge t, then done=1 and busy=0 in cycle t+1. The FSM is IDLE in cycle t+1, and a new req can be sampled at edge t+1.
- Illegal M: err=1 in cycle 1, busy stays 0.
- Timeout: err=1 in the cycle after the DONE_TIMEOUT-th WAIT_DONE cycle; busy=0 in that same cycle.
- rst during any state: at the next edge all outputs return to reset values (prog_en=0 immediately). No Go is issued. The DCM may hold a partial load; the parent must re-request.
- rst and req at the same edge: rst wins; the request is dropped.
- done and err are never asserted together.

## Test plan
- Valid request d_minus1=0x31 (D=50), m_minus1=0x02 (M=3), prog_done low during load then high at cycle 30:
  - LoadD stream on cycles 1–10 is 1,0,1,0,0,0,1,1,0,0.
  - LoadM stream on cycles 13–22 is 1,1,0,1,0,0,0,0,0,0.
  - Go at cycle 25; done=1 at cycle 31.
- m_minus1=0x00 -> err=1 cycle 1, prog_en never asserted, busy=0 throughout.
- DONE_TIMEOUT=8, prog_done held 0 after Go -> err pulse after 8 WAIT_DONE cycles, no done, FSM accepts the next req.
- prog_done held 1 throughout, low for 3 cycles at cycle 28, high at 31 -> done at cycle 32, not earlier.
- rst asserted at cycle 15 (mid-LoadM) -> prog_en=0 and busy=0 from cycle 16; a new req completes normally.
- req held high continuously across two completions -> second request accepted only at the edge after done. A req pulse during busy is ignored; exactly one prog_en burst sequence per accepted req.
